// File: rtl/serial_shift_unit_if.sv
// Bus bundle for serial_shift_unit: shift/load/burst controls in, register state and burst status out.
interface serial_shift_unit_if #(
    parameter int WIDTH = 9
) ();
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             enable;
    logic [1:0]       mode;
    logic             sin;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remain;

    modport master (
        output enable, mode, sin, load, din, start,
        input  q, sout, busy, done, remain
    );

    modport slave (
        input  enable, mode, sin, load, din, start,
        output q, sout, busy, done, remain
    );
endinterface

// File: rtl/serial_shift_unit.sv
// Shift register for bit-serial datapaths with parallel load, right/left/rotate shifts and a
// start/busy/done controller that sequences exactly WIDTH counted shifts per burst.
module serial_shift_unit #(
    parameter int             WIDTH     = 9,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input logic            clk,
    input logic            rst,
    serial_shift_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_s;
    logic [CNT_W-1:0] remain_r;
    logic [CNT_W-1:0] remain_s;
    logic             done_r;
    logic             done_s;
    logic             busy_r;
    logic             busy_s;
    logic             shift_en_s;
    logic             last_shift_s;
    logic [WIDTH-1:0] shifted_s;

    function automatic logic [WIDTH-1:0] shift_op(
        input logic [WIDTH-1:0] cur,
        input logic [1:0]       op,
        input logic             ser_in
    );
        logic [WIDTH-1:0] res;
        case (op)
            2'b01:   res = {ser_in, cur[WIDTH-1:1]};
            2'b10:   res = {cur[WIDTH-2:0], ser_in};
            2'b11:   res = {cur[0], cur[WIDTH-1:1]};
            default: res = cur;
        endcase
        return res;
    endfunction

    // Shift qualification: mode 00 is a hold, so it neither shifts nor counts.
    always_comb begin
        shift_en_s   = bus.enable && (bus.mode != 2'b00);
        last_shift_s = shift_en_s && (remain_r == CNT_W'(1));
        shifted_s    = shift_op(q_r, bus.mode, bus.sin);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: load aborts a burst, the final counted shift ends it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.load) begin
                    state_s = ST_IDLE;
                end else if (last_shift_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values; the start edge itself never shifts.
    always_comb begin
        q_s      = q_r;
        remain_s = remain_r;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.load) begin
                    q_s = bus.din;
                end else if (shift_en_s && !bus.start) begin
                    q_s = shifted_s;
                end else begin
                    q_s = q_r;
                end
                if (bus.start) begin
                    remain_s = CNT_W'(WIDTH);
                end else begin
                    remain_s = {CNT_W{1'b0}};
                end
            end
            ST_SHIFT: begin
                if (bus.load) begin
                    q_s      = bus.din;
                    remain_s = {CNT_W{1'b0}};
                end else if (shift_en_s) begin
                    q_s      = shifted_s;
                    remain_s = remain_r - CNT_W'(1);
                    done_s   = last_shift_s;
                end else begin
                    q_s      = q_r;
                    remain_s = remain_r;
                end
            end
            default: begin
                q_s      = q_r;
                remain_s = {CNT_W{1'b0}};
            end
        endcase
        busy_s = (state_s == ST_SHIFT);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r      <= RESET_VAL;
            remain_r <= {CNT_W{1'b0}};
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            q_r      <= q_s;
            remain_r <= remain_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
        end
    end

    assign bus.q      = q_r;
    assign bus.remain = remain_r;
    assign bus.done   = done_r;
    assign bus.busy   = busy_r;
    // sout is the bit that the next shift in the current mode pushes out.
    assign bus.sout   = (bus.mode == 2'b10) ? q_r[WIDTH-1] : q_r[0];
endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit: an arithmetic reference model checked every cycle plus literal expectations.
module tb_serial_shift_unit;
    localparam int W  = 9;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_shift_unit_if #(.WIDTH(W)) bus ();

    serial_shift_unit #(.WIDTH(W), .RESET_VAL(9'h000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int q;
        int remain;
        bit busy;
        bit done;
    } mstate_t;

    mstate_t m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mstate_t model_next(input mstate_t s, input bit en, input int md,
                                           input bit si, input bit ld, input int d, input bit st);
        mstate_t n;
        int      sh;
        int      mask;
        bit      go;
        n    = s;
        mask = (1 << W) - 1;
        go   = en && (md != 0);
        case (md)
            1:       sh = (s.q >> 1) | (int'(si) << (W - 1));
            2:       sh = ((s.q << 1) | int'(si)) & mask;
            3:       sh = (s.q >> 1) | ((s.q & 1) << (W - 1));
            default: sh = s.q;
        endcase
        n.done = 1'b0;
        if (s.busy) begin
            if (ld) begin
                n.q = d; n.busy = 1'b0; n.remain = 0;
            end else if (go) begin
                n.q = sh;
                n.remain = s.remain - 1;
                if (n.remain == 0) begin
                    n.busy = 1'b0; n.done = 1'b1;
                end
            end
        end else begin
            if (ld) n.q = d;
            else if (go && !st) n.q = sh;
            if (st) begin
                n.busy = 1'b1; n.remain = W;
            end
        end
        return n;
    endfunction

    // Reference model advances on each clock edge from the inputs presented to the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m <= '{q: 0, remain: 0, busy: 1'b0, done: 1'b0};
        end else begin
            m <= model_next(m, bus.enable, int'(bus.mode), bus.sin, bus.load, int'(bus.din), bus.start);
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        chk("q", 32'(bus.q), 32'(m.q));
        chk("busy", 32'(bus.busy), 32'(m.busy));
        chk("done", 32'(bus.done), 32'(m.done));
        chk("remain", 32'(bus.remain), 32'(m.remain));
        chk("sout", 32'(bus.sout),
            (bus.mode == 2'b10) ? 32'((m.q >> (W - 1)) & 1) : 32'(m.q & 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit en, input logic [1:0] md, input bit si,
                         input bit ld, input logic [W-1:0] d, input bit st);
        bus.enable = en; bus.mode = md; bus.sin = si;
        bus.load = ld;   bus.din = d;   bus.start = st;
    endtask

    int busy_cnt;
    int done_cnt;
    bit busy_seen;

    initial begin
        rst = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 9'h000, 1'b0);
        #12 rst = 1'b1;
        tick();

        // Reset asserted mid-burst clears everything without a clock edge.
        drive(1'b1, 2'b01, 1'b1, 1'b1, 9'h1AB, 1'b1);
        tick();
        chk("t1_load_q", 32'(bus.q), 32'h1AB);
        chk("t1_remain", 32'(bus.remain), 32'd9);
        drive(1'b1, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("t1_rst_q", 32'(bus.q), 32'h000);
        chk("t1_rst_busy", 32'(bus.busy), 32'd0);
        chk("t1_rst_done", 32'(bus.done), 32'd0);
        chk("t1_rst_remain", 32'(bus.remain), 32'd0);
        #3 rst = 1'b1;
        tick();

        // Free-running right shift of ones.
        drive(1'b1, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
        busy_seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            busy_seen |= bus.busy;
        end
        chk("t2_q", 32'(bus.q), 32'h1FF);
        chk("t2_busy_seen", 32'(busy_seen), 32'd0);

        // Burst with enable every other cycle.
        drive(1'b0, 2'b01, 1'b0, 1'b1, 9'h0A5, 1'b1);
        tick();
        chk("t3_q", 32'(bus.q), 32'h0A5);
        chk("t3_remain", 32'(bus.remain), 32'd9);
        busy_cnt = int'(bus.busy);
        done_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            drive((k % 2) == 0, 2'b01, 1'b0, 1'b0, 9'h000, 1'b0);
            tick();
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
        end
        chk("t3_busy_cycles", 32'(busy_cnt), 32'd18);
        chk("t3_done_count", 32'(done_cnt), 32'd1);
        chk("t3_final_q", 32'(bus.q), 32'h000);

        // Rotate right and shift left.
        drive(1'b0, 2'b00, 1'b0, 1'b1, 9'h101, 1'b0);
        tick();
        drive(1'b1, 2'b11, 1'b0, 1'b0, 9'h000, 1'b0);
        tick();
        chk("t4_rotate", 32'(bus.q), 32'h180);
        drive(1'b0, 2'b00, 1'b0, 1'b1, 9'h101, 1'b0);
        tick();
        drive(1'b0, 2'b10, 1'b0, 1'b0, 9'h000, 1'b0);
        #1;
        chk("t4_sout_msb", 32'(bus.sout), 32'd1);
        bus.enable = 1'b1;
        tick();
        chk("t4_left", 32'(bus.q), 32'h002);
        chk("t4_sout_after", 32'(bus.sout), 32'd0);

        // Second start ignored, load aborts without done.
        drive(1'b0, 2'b01, 1'b1, 1'b1, 9'h0F0, 1'b1);
        tick();
        drive(1'b1, 2'b01, 1'b1, 1'b0, 9'h000, 1'b0);
        tick(); tick(); tick();
        chk("t5_remain_after3", 32'(bus.remain), 32'd6);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 9'h000, 1'b1);
        tick();
        chk("t5_restart_ignored", 32'(bus.remain), 32'd6);
        chk("t5_still_busy", 32'(bus.busy), 32'd1);
        drive(1'b0, 2'b01, 1'b1, 1'b1, 9'h055, 1'b0);
        tick();
        chk("t5_abort_q", 32'(bus.q), 32'h055);
        chk("t5_abort_busy", 32'(bus.busy), 32'd0);
        chk("t5_abort_done", 32'(bus.done), 32'd0);
        chk("t5_abort_remain", 32'(bus.remain), 32'd0);
        bus.load = 1'b0;
        tick();
        chk("t5_no_late_done", 32'(bus.done), 32'd0);

        // Hold inside a burst, then nine rotates; restart in the done cycle.
        drive(1'b1, 2'b00, 1'b0, 1'b1, 9'h1C3, 1'b1);
        tick();
        drive(1'b1, 2'b00, 1'b0, 1'b0, 9'h000, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_hold_q", 32'(bus.q), 32'h1C3);
        chk("t6_hold_remain", 32'(bus.remain), 32'd9);
        bus.mode = 2'b11;
        for (int i = 0; i < 8; i++) tick();
        chk("t6_busy_at_1", 32'(bus.busy), 32'd1);
        chk("t6_no_early_done", 32'(bus.done), 32'd0);
        chk("t6_remain_1", 32'(bus.remain), 32'd1);
        tick();
        chk("t6_done", 32'(bus.done), 32'd1);
        chk("t6_idle", 32'(bus.busy), 32'd0);
        chk("t6_rot_q", 32'(bus.q), 32'h1C3);
        drive(1'b0, 2'b11, 1'b0, 1'b0, 9'h000, 1'b1);
        tick();
        chk("t6_restart_busy", 32'(bus.busy), 32'd1);
        chk("t6_restart_remain", 32'(bus.remain), 32'd9);
        chk("t6_done_cleared", 32'(bus.done), 32'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b1, 9'h000, 1'b0);
        tick();
        bus.load = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
